// File: rtl/fetch_pkg.sv
// fetch_pkg: BTB/PHT state encoding and fetch defaults shared by the fetch blocks
package fetch_pkg;
  typedef enum logic [1:0] {
    BTB_STATE_WEAK_TAKEN       = 2'b00,
    BTB_STATE_STRONG_TAKEN     = 2'b01,
    BTB_STATE_WEAK_NOT_TAKEN   = 2'b10,
    BTB_STATE_STRONG_NOT_TAKEN = 2'b11
  } btb_state_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int GHR_WIDTH_DEFAULT = 8;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: F1 fetch handshake toward the I-cache request stage
interface fetch_pc_gen_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [1:0]  fetch_pattern;
  logic        fetch_pred_taken;
  logic [31:0] fetch_pred_target;
  modport master (output fetch_valid, fetch_pc, fetch_pattern, fetch_pred_taken, fetch_pred_target, input fetch_ready);
  modport slave (input fetch_valid, fetch_pc, fetch_pattern, fetch_pred_taken, fetch_pred_target, output fetch_ready);
endinterface

// File: rtl/fetch_f1_hold.sv
// fetch_f1_hold: F1 pc/valid/fresh state plus prediction hold registers and source mux
module fetch_f1_hold import fetch_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f0,
  input  logic        redirect_en,
  input  logic [1:0]  bp_pattern,
  input  logic        bp_taken,
  input  logic        bp_target_valid,
  input  logic [31:0] bp_target,
  input  logic        fetch_ready,
  output logic        advance,
  output logic        pred_redir,
  output logic        f1_valid,
  output logic [31:0] pc_f1,
  output logic [1:0]  pattern,
  output logic        pred_taken,
  output logic [31:0] pred_target
);
  logic        f1_fresh, live_taken, hold_taken;
  btb_state_e  hold_pat;
  logic [31:0] hold_target;
  assign live_taken = bp_taken && bp_target_valid;
  assign advance    = !f1_valid || fetch_ready;
  assign pred_redir = f1_valid && f1_fresh && live_taken;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_f1       <= '0;
      f1_valid    <= 1'b0;
      f1_fresh    <= 1'b0;
      hold_pat    <= BTB_STATE_WEAK_TAKEN;
      hold_taken  <= 1'b0;
      hold_target <= '0;
    end else begin
      // a stalled F1 is always valid, so only a flush or a squashing advance clears it
      f1_valid <= !redirect_en && !(pred_redir && advance);
      f1_fresh <= !redirect_en && !pred_redir && advance;
      if (!redirect_en && !pred_redir && advance) pc_f1 <= pc_f0;
      if (f1_fresh) begin
        hold_pat    <= btb_state_e'(bp_pattern);
        hold_taken  <= live_taken;
        hold_target <= bp_target;
      end
    end
  always_comb begin
    pattern     = f1_fresh ? bp_pattern : hold_pat;
    pred_taken  = f1_fresh ? live_taken : hold_taken;
    pred_target = f1_fresh ? bp_target : hold_target;
  end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC mux, GHR register and F0/F1 fetch pipeline ahead of the I-cache
module fetch_pc_gen import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          GHR_WIDTH = GHR_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [31:0]          bpu_pc,
  input  logic [1:0]           bp_pattern,
  input  logic                 bp_taken,
  input  logic                 bp_target_valid,
  input  logic [31:0]          bp_target,
  output logic [GHR_WIDTH-1:0] GHR_rdata,
  input  logic                 GHR_wen,
  input  logic [GHR_WIDTH-1:0] GHR_wdata,
  input  logic                 redirect_en,
  input  logic [31:0]          redirect_pc,
  input  logic [GHR_WIDTH-1:0] redirect_ghr,
  fetch_pc_gen_if.master       fetch
);
  logic [31:0]          pc_f0, pc_next;
  logic [GHR_WIDTH-1:0] ghr, ghr_next;
  logic                 advance, pred_redir;
  fetch_f1_hold u_f1 (
    .clk, .reset, .pc_f0, .redirect_en,
    .bp_pattern, .bp_taken, .bp_target_valid, .bp_target,
    .fetch_ready (fetch.fetch_ready),
    .advance, .pred_redir,
    .f1_valid    (fetch.fetch_valid),
    .pc_f1       (fetch.fetch_pc),
    .pattern     (fetch.fetch_pattern),
    .pred_taken  (fetch.fetch_pred_taken),
    .pred_target (fetch.fetch_pred_target)
  );
  always_comb begin
    pc_next  = redirect_en ? word_align(redirect_pc) : pred_redir ? word_align(bp_target) : advance ? pc_f0 + 32'd4 : pc_f0;
    ghr_next = redirect_en ? redirect_ghr : GHR_wen ? GHR_wdata : ghr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_f0 <= RESET_PC;
      ghr   <= '0;
    end else begin
      pc_f0 <= pc_next;
      ghr   <= ghr_next;
    end
  assign bpu_pc    = pc_f0;
  assign GHR_rdata = ghr;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: scoreboard bench for fetch_pc_gen with a 1-cycle BRAM predictor model
module tb_fetch_pc_gen;
  import fetch_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  pat;
    logic        tk;
    logic [31:0] tgt;
    logic [7:0]  gap;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] bpu_pc, bp_target;
  logic [1:0]  bp_pattern;
  logic        bp_taken, bp_target_valid;
  logic [7:0]  GHR_rdata;
  logic        GHR_wen = 1'b0, redirect_en = 1'b0;
  logic [7:0]  GHR_wdata = '0, redirect_ghr = '0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] bram_pc = '0, tk_pc = '0, tk_tgt = 32'h8000_1000;
  logic        tk_en = 1'b0;
  exp_t        sb[$];
  exp_t        e;
  int          n_run = 0, n_fail = 0, cyc = 0, last_acc = 0;
  fetch_pc_gen_if fif();
  fetch_pc_gen dut (
    .clk, .reset, .bpu_pc, .bp_pattern, .bp_taken, .bp_target_valid, .bp_target,
    .GHR_rdata, .GHR_wen, .GHR_wdata, .redirect_en, .redirect_pc, .redirect_ghr,
    .fetch(fif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // predictor model: registered address, outputs keyed on the sampled PC
  always @(posedge clk) bram_pc <= bpu_pc;
  assign bp_pattern      = bram_pc[3:2];
  assign bp_taken        = tk_en && bram_pc == tk_pc;
  assign bp_target_valid = bp_taken;
  assign bp_target       = tk_tgt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask
  task automatic push(input logic [31:0] pc, input logic tk, input logic [7:0] gap);
    sb.push_back('{pc: pc, pat: pc[3:2], tk: tk, tgt: tk ? tk_tgt : 32'h0, gap: gap});
  endtask
  always @(negedge clk)
    if (!reset && fif.fetch_valid && fif.fetch_ready) begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = '1;
      if (e.gap != 0) chk("sb_gap", cyc - last_acc, 32'(e.gap));
      last_acc = cyc;
      chk("sb_pc", fif.fetch_pc, e.pc);
      chk("sb_pattern", 32'(fif.fetch_pattern), 32'(e.pat));
      chk("sb_taken", 32'(fif.fetch_pred_taken), 32'(e.tk));
      if (e.tk) chk("sb_target", fif.fetch_pred_target, e.tgt);
    end
  initial begin
    fif.fetch_ready = 1'b0;
    // sequential fetch out of reset, plus a plain GHR write
    do_reset();
    fif.fetch_ready = 1'b1;
    GHR_wen = 1'b1;
    GHR_wdata = 8'h5A;
    push(32'hBFC0_0000, 1'b0, 8'd0);
    push(32'hBFC0_0004, 1'b0, 8'd1);
    push(32'hBFC0_0008, 1'b0, 8'd1);
    @(negedge clk);
    chk("rst_bpu_pc", bpu_pc, RESET_PC_DEFAULT);
    chk("rst_valid", 32'(fif.fetch_valid), 32'd0);
    chk("rst_fetch_pc", fif.fetch_pc, 32'd0);
    chk("rst_ghr", 32'(GHR_rdata), 32'd0);
    tick();
    GHR_wen = 1'b0;
    @(negedge clk);
    chk("ghr_write", 32'(GHR_rdata), 32'h5A);
    tick();
    tick();
    tick();
    fif.fetch_ready = 1'b0;
    chk("t1_drain", sb.size(), 32'd0);
    // predicted-taken at BFC00004: one bubble then the target stream
    tk_en = 1'b1;
    tk_pc = 32'hBFC0_0004;
    do_reset();
    fif.fetch_ready = 1'b1;
    push(32'hBFC0_0000, 1'b0, 8'd0);
    push(32'hBFC0_0004, 1'b1, 8'd1);
    push(32'h8000_1000, 1'b0, 8'd2);
    push(32'h8000_1004, 1'b0, 8'd1);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t2_bubble", 32'(fif.fetch_valid), 32'd0);
    chk("t2_bpu_pc", bpu_pc, 32'h8000_1000);
    tick();
    tick();
    tick();
    fif.fetch_ready = 1'b0;
    chk("t2_drain", sb.size(), 32'd0);
    // 3-cycle stall on a fresh F1 while the BRAM output moves on
    tk_en = 1'b0;
    do_reset();
    fif.fetch_ready = 1'b1;
    push(32'hBFC0_0000, 1'b0, 8'd0);
    push(32'hBFC0_0004, 1'b0, 8'd4);
    push(32'hBFC0_0008, 1'b0, 8'd1);
    tick();
    tick();
    fif.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", 32'(fif.fetch_valid), 32'd1);
      chk("t3_stall_pc", fif.fetch_pc, 32'hBFC0_0004);
      chk("t3_stall_pattern", 32'(fif.fetch_pattern), 32'd1);
      tick();
    end
    fif.fetch_ready = 1'b1;
    tick();
    tick();
    fif.fetch_ready = 1'b0;
    chk("t3_drain", sb.size(), 32'd0);
    // redirect coinciding with a GHR write and a predicted-taken F1
    tk_en = 1'b1;
    tk_pc = 32'hBFC0_0004;
    do_reset();
    fif.fetch_ready = 1'b1;
    push(32'hBFC0_0000, 1'b0, 8'd0);
    tick();
    tick();
    fif.fetch_ready = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h8000_2003;
    redirect_ghr = 8'hA5;
    GHR_wen = 1'b1;
    GHR_wdata = 8'h3C;
    @(negedge clk);
    chk("t4_pred_taken", 32'(fif.fetch_pred_taken), 32'd1);
    chk("t4_pred_target", fif.fetch_pred_target, 32'h8000_1000);
    tick();
    redirect_en = 1'b0;
    GHR_wen = 1'b0;
    fif.fetch_ready = 1'b1;
    push(32'h8000_2000, 1'b0, 8'd3);
    push(32'h8000_2004, 1'b0, 8'd1);
    @(negedge clk);
    chk("t4_ghr", 32'(GHR_rdata), 32'hA5);
    chk("t4_bubble", 32'(fif.fetch_valid), 32'd0);
    chk("t4_bpu_pc", bpu_pc, 32'h8000_2000);
    tick();
    tick();
    tick();
    fif.fetch_ready = 1'b0;
    chk("t4_drain", sb.size(), 32'd0);
    // wrap at the top of the address space, then async reset mid-stall
    tk_en = 1'b0;
    do_reset();
    fif.fetch_ready = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFB;
    redirect_ghr = 8'h3C;
    tick();
    redirect_en = 1'b0;
    push(32'hFFFF_FFF8, 1'b0, 8'd0);
    push(32'hFFFF_FFFC, 1'b0, 8'd1);
    push(32'h0000_0000, 1'b0, 8'd1);
    @(negedge clk);
    chk("t5_ghr", 32'(GHR_rdata), 32'h3C);
    chk("t5_bpu_pc", bpu_pc, 32'hFFFF_FFF8);
    tick();
    tick();
    tick();
    tick();
    fif.fetch_ready = 1'b0;
    @(negedge clk);
    chk("t5_stall_valid", 32'(fif.fetch_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(fif.fetch_valid), 32'd0);
    chk("arst_bpu_pc", bpu_pc, RESET_PC_DEFAULT);
    chk("arst_fetch_pc", fif.fetch_pc, 32'd0);
    chk("arst_pattern", 32'(fif.fetch_pattern), 32'd0);
    chk("arst_ghr", 32'(GHR_rdata), 32'd0);
    chk("t5_drain", sb.size(), 32'd0);
    tick();
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
